// File: rtl/keccak_sponge_seq_if.sv
// -----------------------------------------------------------------------------
// keccak_sponge_seq_if
// Handshake bundle between the Keccak sponge sequencer and its environment
// (message source, digest sink and permutation core).
//
// Signals
//   start       : begin a new hash (honoured only while the sequencer is idle)
//   rate        : lanes per block, 1..25, latched on an accepted start
//   out_lanes   : number of digest lanes to squeeze, latched on accepted start
//   din_valid   : absorb lane valid
//   din_last    : current absorb lane is the last lane of the padded message
//   din_ready   : sequencer accepts an absorb lane
//   absorb_we   : XOR-enable of the current lane into the state
//   dout_valid  : squeeze lane valid
//   dout_ready  : sink accepts a squeeze lane
//   lane_idx    : current lane index within the block
//   perm_ini    : one-cycle permutation start
//   perm_fin    : permutation core finished
//   busy        : sequencer is not idle
//   done        : one-cycle completion pulse
//   err         : sticky error flag
//
// Modports
//   master : environment side (drives requests, data handshakes, perm_fin)
//   slave  : sequencer side
// -----------------------------------------------------------------------------
interface keccak_sponge_seq_if;
  logic        start;
  logic [4:0]  rate;
  logic [15:0] out_lanes;
  logic        din_valid;
  logic        din_last;
  logic        din_ready;
  logic        absorb_we;
  logic        dout_valid;
  logic        dout_ready;
  logic [4:0]  lane_idx;
  logic        perm_ini;
  logic        perm_fin;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, rate, out_lanes, din_valid, din_last, dout_ready, perm_fin,
    input  din_ready, absorb_we, dout_valid, lane_idx, perm_ini, busy, done, err
  );

  modport slave (
    input  start, rate, out_lanes, din_valid, din_last, dout_ready, perm_fin,
    output din_ready, absorb_we, dout_valid, lane_idx, perm_ini, busy, done, err
  );
endinterface

// File: rtl/keccak_sponge_seq.sv
// -----------------------------------------------------------------------------
// keccak_sponge_seq
// Control sequencer for a Keccak sponge. It walks a hash through
//   IDLE -> ABSORB -> PERM -> (ABSORB -> PERM)* -> SQUEEZE -> (PERM -> SQUEEZE)*
//   -> DONE -> IDLE
// steering the lane index, the absorb XOR enable and the permutation core
// start pulse. The datapath (state array, permutation rounds) lives outside.
//
// Ports
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : keccak_sponge_seq_if.slave (see interface file for signal list)
//
// Parameters
//   TIMEOUT : maximum number of PERM cycles waiting for perm_fin; only used
//             when the KECCAK_SEQ_TIMEOUT_EN macro is defined.
//
// Build option
//   KECCAK_SEQ_TIMEOUT_EN : when defined, a watchdog counts PERM cycles and
//   aborts the hash (err=1, back to IDLE, no done pulse) after TIMEOUT cycles
//   without perm_fin. When undefined, PERM waits for perm_fin indefinitely.
// -----------------------------------------------------------------------------
module keccak_sponge_seq #(
  parameter int TIMEOUT = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  keccak_sponge_seq_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ABSORB  = 3'd1,
    S_PERM    = 3'd2,
    S_SQUEEZE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t      r_state;
  logic [4:0]  r_rate;
  logic [15:0] r_out_rem;
  logic [4:0]  r_lane_idx;
  logic        r_sqz;        // PERM returns to SQUEEZE when set, else ABSORB
  logic        r_din_ready;
  logic        r_dout_valid;
  logic        r_perm_ini;
  logic        r_busy;
  logic        r_done;
  logic        r_err;

  logic        w_cfg_ok;
  logic        w_block_end;
  logic        w_absorb_hs;
  logic        w_squeeze_hs;
  logic        w_perm_fin;

  // A start is only accepted with a legal rate and a non-empty digest.
  assign w_cfg_ok     = (bus.rate != 5'd0) && (bus.rate <= 5'd25) &&
                        (bus.out_lanes != 16'd0);
  assign w_block_end  = (r_lane_idx == (r_rate - 5'd1));
  assign w_absorb_hs  = bus.din_valid  & r_din_ready;
  assign w_squeeze_hs = bus.dout_ready & r_dout_valid;
  // perm_fin is ignored in the cycle that issues perm_ini: the core cannot
  // have finished a permutation it has not been told to start yet.
  assign w_perm_fin   = bus.perm_fin & ~r_perm_ini;

`ifdef KECCAK_SEQ_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TMO_W-1:0] r_tmo_cnt;
  logic             w_tmo_hit;
  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
`endif

  // NOTE: state is updated with non-blocking assignments so every branch
  // reads the values from before this edge, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_rate       <= 5'd0;
      r_out_rem    <= 16'd0;
      r_lane_idx   <= 5'd0;
      r_sqz        <= 1'b0;
      r_din_ready  <= 1'b0;
      r_dout_valid <= 1'b0;
      r_perm_ini   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef KECCAK_SEQ_TIMEOUT_EN
      r_tmo_cnt    <= '0;
`endif
    end else begin
      // Single-cycle pulses default low.
      r_perm_ini <= 1'b0;
      r_done     <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_cfg_ok) begin
              r_state     <= S_ABSORB;
              r_rate      <= bus.rate;
              r_out_rem   <= bus.out_lanes;
              r_lane_idx  <= 5'd0;
              r_sqz       <= 1'b0;
              r_err       <= 1'b0;
              r_din_ready <= 1'b1;
              r_busy      <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end

        S_ABSORB: begin
          if (w_absorb_hs) begin
            if (w_block_end || bus.din_last) begin
              // Block full or message over: permute before anything else.
              r_state     <= S_PERM;
              r_perm_ini  <= 1'b1;
              r_lane_idx  <= 5'd0;
              r_din_ready <= 1'b0;
              if (bus.din_last) r_sqz <= 1'b1;
`ifdef KECCAK_SEQ_TIMEOUT_EN
              r_tmo_cnt   <= '0;
`endif
            end else begin
              r_lane_idx <= r_lane_idx + 5'd1;
            end
          end
        end

        S_PERM: begin
          if (w_perm_fin) begin
            r_lane_idx <= 5'd0;
            if (r_sqz) begin
              r_state      <= S_SQUEEZE;
              r_dout_valid <= 1'b1;
            end else begin
              r_state     <= S_ABSORB;
              r_din_ready <= 1'b1;
            end
          end
`ifdef KECCAK_SEQ_TIMEOUT_EN
          else if (w_tmo_hit) begin
            // Core never answered: abort without a done pulse.
            r_state    <= S_IDLE;
            r_err      <= 1'b1;
            r_busy     <= 1'b0;
            r_lane_idx <= 5'd0;
            r_out_rem  <= 16'd0;
            r_sqz      <= 1'b0;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
`endif
        end

        S_SQUEEZE: begin
          if (w_squeeze_hs) begin
            r_out_rem <= r_out_rem - 16'd1;
            // Digest exhausted wins over a coincident block end: no point
            // permuting for lanes nobody will read.
            if (r_out_rem == 16'd1) begin
              r_state      <= S_DONE;
              r_dout_valid <= 1'b0;
              r_done       <= 1'b1;
              r_lane_idx   <= 5'd0;
            end else if (w_block_end) begin
              r_state      <= S_PERM;
              r_perm_ini   <= 1'b1;
              r_lane_idx   <= 5'd0;
              r_dout_valid <= 1'b0;
`ifdef KECCAK_SEQ_TIMEOUT_EN
              r_tmo_cnt    <= '0;
`endif
            end else begin
              r_lane_idx <= r_lane_idx + 5'd1;
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_sqz   <= 1'b0;
        end

        default: begin
          r_state      <= S_IDLE;
          r_busy       <= 1'b0;
          r_din_ready  <= 1'b0;
          r_dout_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.din_ready  = r_din_ready;
  assign bus.dout_valid = r_dout_valid;
  assign bus.absorb_we  = w_absorb_hs;
  assign bus.lane_idx   = r_lane_idx;
  assign bus.perm_ini   = r_perm_ini;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.err        = r_err;

endmodule

// File: tb/tb_keccak_sponge_seq.sv
// -----------------------------------------------------------------------------
// tb_keccak_sponge_seq
// Self-checking bench for keccak_sponge_seq. Expected squeeze lane indices are
// queued when a hash is launched and popped by a monitor on every squeeze
// handshake. A background responder answers perm_ini with perm_fin after a
// programmable latency.
// -----------------------------------------------------------------------------
module tb_keccak_sponge_seq;

  logic clk;
  logic rst;
  keccak_sponge_seq_if ifc();

  keccak_sponge_seq #(.TIMEOUT(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int perm_cnt;
  int done_cnt;
  int perm_lat;
  bit perm_auto;
  int exp_q[$];

  // Squeeze scoreboard plus event counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.perm_ini) perm_cnt++;
      if (ifc.done) done_cnt++;
      if (ifc.dout_valid && ifc.dout_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sqz_unexpected: got lane_idx %0d, required no squeeze beat", ifc.lane_idx);
        end else begin
          int e;
          e = exp_q.pop_front();
          if (ifc.lane_idx !== 5'(e)) begin
            errors++;
            $display("FAIL sqz_lane: got %0d, required %0d", ifc.lane_idx, e);
          end
        end
      end
    end
  end

  // Permutation core model.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (perm_auto && ifc.perm_ini) begin
        repeat (perm_lat) @(posedge clk);
        #1 ifc.perm_fin = 1'b1;
        @(posedge clk);
        #1 ifc.perm_fin = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    step();
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({ifc.busy, ifc.done, ifc.err, ifc.din_ready, ifc.dout_valid,
         ifc.perm_ini, ifc.absorb_we} !== 7'b0 || ifc.lane_idx !== 5'd0) begin
      errors++;
      $display("FAIL %s: got busy/done/err/dr/dv/pi/we=%b lane=%0d, required all 0",
               tag, {ifc.busy, ifc.done, ifc.err, ifc.din_ready, ifc.dout_valid,
                     ifc.perm_ini, ifc.absorb_we}, ifc.lane_idx);
    end
  endtask

  task automatic send_beat(input bit last, input int exp_lane);
    int n;
    ifc.din_valid = 1'b1;
    ifc.din_last  = last;
    n = 0;
    @(negedge clk);
    while (!ifc.din_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL din_ready_timeout: got no din_ready in 200 cycles, required handshake");
    end else if (ifc.lane_idx !== 5'(exp_lane) || ifc.absorb_we !== 1'b1) begin
      errors++;
      $display("FAIL absorb_beat: got lane %0d we %b, required lane %0d we 1",
               ifc.lane_idx, ifc.absorb_we, exp_lane);
    end
    step();
    ifc.din_valid = 1'b0;
    ifc.din_last  = 1'b0;
  endtask

  // Launch a hash, absorb nb lanes, squeeze ol lanes; checks every step.
  task automatic run_hash(input int r, input int ol, input int nb, input int lat,
                          input bit poke_start);
    int n;
    int exp_perm;
    perm_lat  = lat;
    perm_auto = 1'b1;
    perm_cnt  = 0;
    done_cnt  = 0;
    exp_perm  = (nb + r - 1) / r + (ol + r - 1) / r - 1;
    for (int k = 0; k < ol; k++) exp_q.push_back(k % r);

    ifc.start     = 1'b1;
    ifc.rate      = 5'(r);
    ifc.out_lanes = 16'(ol);
    step();
    ifc.start = 1'b0;
    checks++;
    if (ifc.busy !== 1'b1 || ifc.err !== 1'b0 || ifc.din_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_accept: got busy %b err %b din_ready %b, required 1 0 1",
               ifc.busy, ifc.err, ifc.din_ready);
    end

    if (poke_start) begin
      // Illegal start while absorbing must be ignored completely.
      ifc.start     = 1'b1;
      ifc.rate      = 5'd0;
      ifc.out_lanes = 16'd0;
      step();
      ifc.start = 1'b0;
      checks++;
      if (ifc.err !== 1'b0 || ifc.busy !== 1'b1 || ifc.lane_idx !== 5'd0 ||
          ifc.din_ready !== 1'b1) begin
        errors++;
        $display("FAIL start_ignored: got err %b busy %b lane %0d dr %b, required 0 1 0 1",
                 ifc.err, ifc.busy, ifc.lane_idx, ifc.din_ready);
      end
    end

    for (int i = 0; i < nb; i++) begin
      send_beat(i == nb - 1, i % r);
      if ((i % r) == r - 1 || i == nb - 1) begin
        checks++;
        if (ifc.perm_ini !== 1'b1 || ifc.din_ready !== 1'b0) begin
          errors++;
          $display("FAIL perm_ini_after_beat%0d: got pi %b dr %b, required 1 0",
                   i + 1, ifc.perm_ini, ifc.din_ready);
        end
      end
    end

    ifc.dout_ready = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ifc.done && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 3000) begin
      errors++;
      $display("FAIL done_timeout: got no done in 3000 cycles, required done pulse");
    end
    step();
    ifc.dout_ready = 1'b0;
    checks++;
    if (ifc.busy !== 1'b0 || ifc.done !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL done_once: got busy %b done %b done_cnt %0d, required 0 0 1",
               ifc.busy, ifc.done, done_cnt);
    end
    checks++;
    if (perm_cnt != exp_perm) begin
      errors++;
      $display("FAIL perm_count: got %0d, required %0d", perm_cnt, exp_perm);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sqz_missing: got %0d lanes outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    check_idle_outputs("reset_held");
    apply_reset();
    check_idle_outputs("reset_released");
  endtask

  task automatic test_rate17();
    run_hash(17, 4, 17, 24, 1'b1);
  endtask

  task automatic test_multi_block();
    run_hash(21, 2, 30, 5, 1'b0);
  endtask

  task automatic test_multi_squeeze();
    run_hash(2, 5, 1, 3, 1'b0);
  endtask

  task automatic test_bad_start();
    int bad_rate [3] = '{0, 26, 5};
    int bad_out  [3] = '{4, 4, 0};
    for (int i = 0; i < 3; i++) begin
      ifc.start     = 1'b1;
      ifc.rate      = 5'(bad_rate[i]);
      ifc.out_lanes = 16'(bad_out[i]);
      step();
      ifc.start = 1'b0;
      checks++;
      if (ifc.err !== 1'b1 || ifc.busy !== 1'b0 || ifc.din_ready !== 1'b0) begin
        errors++;
        $display("FAIL bad_start_%0d: got err %b busy %b dr %b, required 1 0 0",
                 i, ifc.err, ifc.busy, ifc.din_ready);
      end
    end
    // A legal start clears err (checked inside run_hash).
    run_hash(3, 3, 4, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_hash(4, 2, 3, 1, 1'b0);
    run_hash(1, 3, 2, 2, 1'b0);
  endtask

  task automatic test_reset_mid();
    int n;
    // Mid-PERM: no responder, so the sequencer parks in PERM.
    perm_auto = 1'b0;
    done_cnt  = 0;
    ifc.start = 1'b1; ifc.rate = 5'd2; ifc.out_lanes = 16'd5;
    step();
    ifc.start = 1'b0;
    send_beat(1'b1, 0);
    repeat (3) step();
    #3 rst = 1'b1;
    #1 check_idle_outputs("rst_mid_perm");
    @(posedge clk); #1 rst = 1'b0;
    step();
    check_idle_outputs("after_rst_perm");

    // Mid-SQUEEZE: hold dout_ready low so the squeeze stalls.
    perm_auto = 1'b1;
    perm_lat  = 2;
    ifc.start = 1'b1; ifc.rate = 5'd4; ifc.out_lanes = 16'd8;
    step();
    ifc.start = 1'b0;
    send_beat(1'b1, 0);
    n = 0;
    while (!ifc.dout_valid && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL reach_squeeze: got no dout_valid in 100 cycles, required squeeze");
    end
    #3 rst = 1'b1;
    #1 check_idle_outputs("rst_mid_squeeze");
    @(posedge clk); #1 rst = 1'b0;
    step();
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL rst_no_done: got %0d done pulses, required 0", done_cnt);
    end

    // Stray perm_fin in IDLE must change nothing.
    perm_auto = 1'b0;
    ifc.perm_fin = 1'b1;
    step();
    ifc.perm_fin = 1'b0;
    step();
    check_idle_outputs("stray_perm_fin");
  endtask

  task automatic test_perm_wait();
    perm_auto = 1'b0;
    done_cnt  = 0;
    ifc.start = 1'b1; ifc.rate = 5'd2; ifc.out_lanes = 16'd1;
    step();
    ifc.start = 1'b0;
    send_beat(1'b1, 0);
`ifdef KECCAK_SEQ_TIMEOUT_EN
    // The perm_ini cycle is PERM cycle 1; after 32 cycles it aborts.
    repeat (31) step();
    checks++;
    if (ifc.busy !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: got busy %b at PERM cycle 32, required 1", ifc.busy);
    end
    step();
    checks++;
    if (ifc.busy !== 1'b0 || ifc.err !== 1'b1 || done_cnt != 0) begin
      errors++;
      $display("FAIL timeout_abort: got busy %b err %b done_cnt %0d, required 0 1 0",
               ifc.busy, ifc.err, done_cnt);
    end
`else
    repeat (1000) step();
    checks++;
    if (ifc.busy !== 1'b1 || ifc.err !== 1'b0 || ifc.din_ready !== 1'b0 ||
        ifc.dout_valid !== 1'b0 || done_cnt != 0) begin
      errors++;
      $display("FAIL perm_wait: got busy %b err %b dr %b dv %b done_cnt %0d, required 1 0 0 0 0",
               ifc.busy, ifc.err, ifc.din_ready, ifc.dout_valid, done_cnt);
    end
`endif
    apply_reset();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    perm_cnt = 0;
    done_cnt = 0;
    perm_lat = 1;
    perm_auto = 1'b0;
    ifc.start = 1'b0;
    ifc.rate = 5'd0;
    ifc.out_lanes = 16'd0;
    ifc.din_valid = 1'b0;
    ifc.din_last = 1'b0;
    ifc.dout_ready = 1'b0;
    ifc.perm_fin = 1'b0;

    test_reset();
    test_rate17();
    test_multi_block();
    test_multi_squeeze();
    test_bad_start();
    test_back_to_back();
    test_reset_mid();
    test_perm_wait();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
